// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator.
//
// Produces the horizontal/vertical position, sync strobes, visible/blank
// and VRAM-writable flags, a pixel-enable divider, registered line/frame/
// vblank event pulses and a completed-frame counter.
//
// Ports:
//   clk_12_5875     in   system/pixel clock
//   rst             in   synchronous, active-high reset
//   en_i            in   advance enable; 0 freezes all timing state
//   hsync_o         out  horizontal sync, active level HSYNC_POL
//   vsync_o         out  vertical sync, active level VSYNC_POL
//   hcounter_o      out  current pixel column
//   vcounter_o      out  current line
//   visible_o       out  inside the active picture
//   hblank_o        out  outside the active columns
//   vblank_o        out  outside the active lines
//   writable_o      out  VRAM writable window (same as vblank_o)
//   pix_en_o        out  last clock of the current pixel period
//   line_start_o    out  one-clock pulse on the first clock of column 0
//   frame_start_o   out  one-clock pulse on the first clock of (0,0) after a wrap
//   vblank_start_o  out  one-clock pulse on the first clock of line V_VISIBLE
//   frame_count_o   out  completed-frame count (wraps at 2^FRAME_W)
module video_timing_gen #(
  parameter int unsigned H_VISIBLE = 320,
  parameter int unsigned H_FRONT   = 8,
  parameter int unsigned H_SYNC    = 48,
  parameter int unsigned H_BACK    = 24,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned PIX_DIV   = 1,
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned FRAME_W   = 8
) (
  input  logic               clk_12_5875,
  input  logic               rst,
  input  logic               en_i,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic [CNT_W-1:0]   hcounter_o,
  output logic [CNT_W-1:0]   vcounter_o,
  output logic               visible_o,
  output logic               hblank_o,
  output logic               vblank_o,
  output logic               writable_o,
  output logic               pix_en_o,
  output logic               line_start_o,
  output logic               frame_start_o,
  output logic               vblank_start_o,
  output logic [FRAME_W-1:0] frame_count_o
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_VIS_LAST = CNT_W'(V_VISIBLE - 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(PIX_DIV - 1);

  // Elaboration-time sanity checks on the geometry.
  if (H_TOTAL > (32'd1 << CNT_W)) begin : g_chk_h_total
    $error("video_timing_gen: H_TOTAL does not fit in CNT_W bits");
  end
  if (V_TOTAL > (32'd1 << CNT_W)) begin : g_chk_v_total
    $error("video_timing_gen: V_TOTAL does not fit in CNT_W bits");
  end
  if (PIX_DIV < 1) begin : g_chk_pix_div
    $error("video_timing_gen: PIX_DIV must be at least 1");
  end

  logic [DIV_W-1:0]   r_div;
  logic [CNT_W-1:0]   r_h;
  logic [CNT_W-1:0]   r_v;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic               r_line_start;
  logic               r_frame_start;
  logic               r_vblank_start;

  logic w_adv;
  logic w_h_last;
  logic w_v_last;
  logic w_v_vis_last;
  logic w_hvis;
  logic w_vvis;
  logic w_hsync_act;
  logic w_vsync_act;

  // Position advances on the last clock of each pixel period.
  assign w_adv        = en_i & (r_div == DIV_LAST) & ~rst;
  assign w_h_last     = (r_h == H_LAST);
  assign w_v_last     = (r_v == V_LAST);
  assign w_v_vis_last = (r_v == V_VIS_LAST);

  // Region decode straight from the counters; reset masks everything.
  assign w_hvis      = ~rst & (32'(r_h) < H_VISIBLE);
  assign w_vvis      = ~rst & (32'(r_v) < V_VISIBLE);
  assign w_hsync_act = ~rst & (32'(r_h) >= HS_START) & (32'(r_h) < HS_END);
  assign w_vsync_act = ~rst & (32'(r_v) >= VS_START) & (32'(r_v) < VS_END);

  // Divider, raster position, event pulses and frame counter.
  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      r_div          <= '0;
      r_h            <= '0;
      r_v            <= '0;
      r_frame_cnt    <= '0;
      r_line_start   <= 1'b0;
      r_frame_start  <= 1'b0;
      r_vblank_start <= 1'b0;
    end else begin
      if (en_i) begin
        r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      end
      if (w_adv) begin
        r_h <= w_h_last ? '0 : r_h + 1'b1;
        if (w_h_last) begin
          r_v <= w_v_last ? '0 : r_v + 1'b1;
        end
      end
      // Pulses line up with the counter value they announce.
      r_line_start   <= w_adv & w_h_last;
      r_frame_start  <= w_adv & w_h_last & w_v_last;
      r_vblank_start <= w_adv & w_h_last & w_v_vis_last;
      if (w_adv & w_h_last & w_v_last) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign hsync_o        = w_hsync_act ? HSYNC_POL : ~HSYNC_POL;
  assign vsync_o        = w_vsync_act ? VSYNC_POL : ~VSYNC_POL;
  assign hcounter_o     = r_h;
  assign vcounter_o     = r_v;
  assign visible_o      = w_hvis & w_vvis;
  assign hblank_o       = ~w_hvis;
  assign vblank_o       = ~w_vvis;
  assign writable_o     = ~w_vvis;
  assign pix_en_o       = w_adv;
  assign line_start_o   = r_line_start;
  assign frame_start_o  = r_frame_start;
  assign vblank_start_o = r_vblank_start;
  assign frame_count_o  = r_frame_cnt;

endmodule

// File: tb/tb_video_timing_gen.sv
// Testbench for video_timing_gen: three instances (default geometry, a small
// geometry with a 2-bit frame counter, and a small geometry with PIX_DIV=2 and
// inverted sync polarity) checked every cycle against an arithmetic raster
// model, plus a vector table and hand-written corner-case sequences.
module tb_video_timing_gen;

  typedef struct packed {
    int unsigned hvis, hfp, hsw, hbp, vvis, vfp, vsw, vbp, pd, fw;
    bit hpol, vpol;
  } geom_t;

  // Model state: n = pixel advances since reset, e = enabled clocks since reset.
  typedef struct packed {
    longint unsigned n, e;
    bit ls, fs, vbs;
  } mst_t;

  typedef struct packed {
    logic [31:0] h, v, fc;
    logic hs, vs, vis, hbl, vbl, wr, pe, ls, fs, vbs;
  } obs_t;

  typedef struct packed {
    int unsigned cyc, h, v;
    bit hs, vis, hbl, ls;
  } vec_t;

  localparam geom_t G_DEF = '{320, 8, 48, 24, 480, 10, 2, 33, 1, 8, 1'b0, 1'b0};
  localparam geom_t G_SM  = '{20, 2, 4, 3, 12, 2, 2, 3, 1, 2, 1'b0, 1'b0};
  localparam geom_t G_DV  = '{20, 2, 4, 3, 12, 2, 2, 3, 2, 8, 1'b1, 1'b1};
  localparam int NV = 11;

  logic clk;
  logic rst_def, en_def, rst_sm, en_sm, rst_dv, en_dv;

  logic [9:0] d_h, d_v;
  logic [7:0] d_fc;
  logic d_hs, d_vs, d_vis, d_hbl, d_vbl, d_wr, d_pe, d_ls, d_fs, d_vbs;
  logic [5:0] s_h, s_v;
  logic [1:0] s_fc;
  logic s_hs, s_vs, s_vis, s_hbl, s_vbl, s_wr, s_pe, s_ls, s_fs, s_vbs;
  logic [5:0] q_h, q_v;
  logic [7:0] q_fc;
  logic q_hs, q_vs, q_vis, q_hbl, q_vbl, q_wr, q_pe, q_ls, q_fs, q_vbs;

  obs_t o_def, o_sm, o_dv;
  mst_t m_def, m_sm, m_dv;
  vec_t vec [NV];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  video_timing_gen u_def (
    .clk_12_5875(clk), .rst(rst_def), .en_i(en_def),
    .hsync_o(d_hs), .vsync_o(d_vs), .hcounter_o(d_h), .vcounter_o(d_v),
    .visible_o(d_vis), .hblank_o(d_hbl), .vblank_o(d_vbl), .writable_o(d_wr),
    .pix_en_o(d_pe), .line_start_o(d_ls), .frame_start_o(d_fs),
    .vblank_start_o(d_vbs), .frame_count_o(d_fc)
  );

  video_timing_gen #(
    .H_VISIBLE(20), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIX_DIV(1), .CNT_W(6), .FRAME_W(2)
  ) u_sm (
    .clk_12_5875(clk), .rst(rst_sm), .en_i(en_sm),
    .hsync_o(s_hs), .vsync_o(s_vs), .hcounter_o(s_h), .vcounter_o(s_v),
    .visible_o(s_vis), .hblank_o(s_hbl), .vblank_o(s_vbl), .writable_o(s_wr),
    .pix_en_o(s_pe), .line_start_o(s_ls), .frame_start_o(s_fs),
    .vblank_start_o(s_vbs), .frame_count_o(s_fc)
  );

  video_timing_gen #(
    .H_VISIBLE(20), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIX_DIV(2), .CNT_W(6), .FRAME_W(8)
  ) u_dv (
    .clk_12_5875(clk), .rst(rst_dv), .en_i(en_dv),
    .hsync_o(q_hs), .vsync_o(q_vs), .hcounter_o(q_h), .vcounter_o(q_v),
    .visible_o(q_vis), .hblank_o(q_hbl), .vblank_o(q_vbl), .writable_o(q_wr),
    .pix_en_o(q_pe), .line_start_o(q_ls), .frame_start_o(q_fs),
    .vblank_start_o(q_vbs), .frame_count_o(q_fc)
  );

  assign o_def = '{32'(d_h), 32'(d_v), 32'(d_fc), d_hs, d_vs, d_vis, d_hbl, d_vbl, d_wr, d_pe, d_ls, d_fs, d_vbs};
  assign o_sm  = '{32'(s_h), 32'(s_v), 32'(s_fc), s_hs, s_vs, s_vis, s_hbl, s_vbl, s_wr, s_pe, s_ls, s_fs, s_vbs};
  assign o_dv  = '{32'(q_h), 32'(q_v), 32'(q_fc), q_hs, q_vs, q_vis, q_hbl, q_vbl, q_wr, q_pe, q_ls, q_fs, q_vbs};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Expected outputs from the raster position implied by the advance count.
  function automatic obs_t model_out(geom_t g, mst_t m, logic en, logic rst);
    obs_t o;
    longint unsigned ht, vt, fl, h, v;
    ht = 64'(g.hvis + g.hfp + g.hsw + g.hbp);
    vt = 64'(g.vvis + g.vfp + g.vsw + g.vbp);
    fl = ht * vt;
    h = m.n % ht;
    v = (m.n / ht) % vt;
    o.h   = 32'(h);
    o.v   = 32'(v);
    o.fc  = 32'((m.n / fl) % (64'd1 << g.fw));
    o.vis = !rst && (h < 64'(g.hvis)) && (v < 64'(g.vvis));
    o.hbl = rst || (h >= 64'(g.hvis));
    o.vbl = rst || (v >= 64'(g.vvis));
    o.wr  = o.vbl;
    o.hs  = (!rst && h >= 64'(g.hvis + g.hfp) && h < 64'(g.hvis + g.hfp + g.hsw)) ? g.hpol : !g.hpol;
    o.vs  = (!rst && v >= 64'(g.vvis + g.vfp) && v < 64'(g.vvis + g.vfp + g.vsw)) ? g.vpol : !g.vpol;
    o.pe  = en && !rst && ((m.e % 64'(g.pd)) == 64'(g.pd - 1));
    o.ls  = m.ls;
    o.fs  = m.fs;
    o.vbs = m.vbs;
    return o;
  endfunction

  function automatic mst_t model_step(geom_t g, mst_t m, logic en, logic rst);
    mst_t r;
    longint unsigned ht, fl;
    bit adv;
    ht = 64'(g.hvis + g.hfp + g.hsw + g.hbp);
    fl = ht * 64'(g.vvis + g.vfp + g.vsw + g.vbp);
    r = '0;
    if (rst) return r;
    adv = en && ((m.e % 64'(g.pd)) == 64'(g.pd - 1));
    r.e = en ? m.e + 1 : m.e;
    r.n = adv ? m.n + 1 : m.n;
    r.ls  = adv && (r.n % ht == 0);
    r.fs  = adv && (r.n % fl == 0);
    r.vbs = adv && (r.n % fl == 64'(g.vvis) * ht);
    return r;
  endfunction

  task automatic cmp_obs(input string tag, input obs_t a, input obs_t e);
    chk({tag, ".h"},   a.h, e.h);
    chk({tag, ".v"},   a.v, e.v);
    chk({tag, ".fc"},  a.fc, e.fc);
    chk({tag, ".hs"},  32'(a.hs), 32'(e.hs));
    chk({tag, ".vs"},  32'(a.vs), 32'(e.vs));
    chk({tag, ".vis"}, 32'(a.vis), 32'(e.vis));
    chk({tag, ".hbl"}, 32'(a.hbl), 32'(e.hbl));
    chk({tag, ".vbl"}, 32'(a.vbl), 32'(e.vbl));
    chk({tag, ".wr"},  32'(a.wr), 32'(e.wr));
    chk({tag, ".pe"},  32'(a.pe), 32'(e.pe));
    chk({tag, ".ls"},  32'(a.ls), 32'(e.ls));
    chk({tag, ".fs"},  32'(a.fs), 32'(e.fs));
    chk({tag, ".vbs"}, 32'(a.vbs), 32'(e.vbs));
  endtask

  // Compare all instances with the model, then advance one clock.
  task automatic tick();
    #1;
    cmp_obs("def", o_def, model_out(G_DEF, m_def, en_def, rst_def));
    cmp_obs("sm",  o_sm,  model_out(G_SM,  m_sm,  en_sm,  rst_sm));
    cmp_obs("dv",  o_dv,  model_out(G_DV,  m_dv,  en_dv,  rst_dv));
    @(posedge clk);
    m_def = model_step(G_DEF, m_def, en_def, rst_def);
    m_sm  = model_step(G_SM,  m_sm,  en_sm,  rst_sm);
    m_dv  = model_step(G_DV,  m_dv,  en_dv,  rst_dv);
    @(negedge clk);
  endtask

  initial begin
    int ti;
    int vbs_cnt, vbs_at, vbs_h, vbs_v, vs_low, bad_vs, bad_wr, ls_cnt;
    int fs_sm_at, fs_sm_fc, bad_pe, bad_h, bad_hs, hs_hi, vs_hi, fs_dv_at, fs_dv_fc;
    bit found;

      // cycle, h, v, hsync, visible, hblank, line_start (default geometry)
    vec[0]  = '{0,   0,   0, 1'b1, 1'b1, 1'b0, 1'b0};
    vec[1]  = '{1,   1,   0, 1'b1, 1'b1, 1'b0, 1'b0};
    vec[2]  = '{319, 319, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    vec[3]  = '{320, 320, 0, 1'b1, 1'b0, 1'b1, 1'b0};
    vec[4]  = '{327, 327, 0, 1'b1, 1'b0, 1'b1, 1'b0};
    vec[5]  = '{328, 328, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[6]  = '{375, 375, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[7]  = '{376, 376, 0, 1'b1, 1'b0, 1'b1, 1'b0};
    vec[8]  = '{399, 399, 0, 1'b1, 1'b0, 1'b1, 1'b0};
    vec[9]  = '{400, 0,   1, 1'b1, 1'b1, 1'b0, 1'b1};
    vec[10] = '{401, 1,   1, 1'b1, 1'b1, 1'b0, 1'b0};

    ti = 0; vbs_cnt = 0; vbs_at = -1; vbs_h = -1; vbs_v = -1; vs_low = 0;
    bad_vs = 0; bad_wr = 0; ls_cnt = 0; fs_sm_at = -1; fs_sm_fc = -1;
    bad_pe = 0; bad_h = 0; bad_hs = 0; hs_hi = 0; vs_hi = 0; fs_dv_at = -1; fs_dv_fc = -1;

    rst_def = 1'b1; rst_sm = 1'b1; rst_dv = 1'b1;
    en_def = 1'b1; en_sm = 1'b1; en_dv = 1'b1;
    m_def = '0; m_sm = '0; m_dv = '0;
    @(posedge clk);
    m_def = model_step(G_DEF, m_def, en_def, rst_def);
    m_sm  = model_step(G_SM,  m_sm,  en_sm,  rst_sm);
    m_dv  = model_step(G_DV,  m_dv,  en_dv,  rst_dv);
    @(negedge clk);

    // Reset held for three clocks in total.
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rst_vis", 32'(d_vis), 0);
      chk("rst_hblank", 32'(d_hbl), 1);
      chk("rst_vblank", 32'(d_vbl), 1);
      chk("rst_writable", 32'(d_wr), 1);
      chk("rst_hsync", 32'(d_hs), 1);
      chk("rst_vsync", 32'(d_vs), 1);
      chk("rst_pix_en", 32'(d_pe), 0);
      chk("rst_hcount", 32'(d_h), 0);
      chk("rst_dv_hsync", 32'(q_hs), 0);
      chk("rst_dv_vsync", 32'(q_vs), 0);
      tick();
    end

    rst_def = 1'b0; rst_sm = 1'b0; rst_dv = 1'b0;
    for (int c = 0; c < 1106; c++) begin
      #1;
      if (ti < NV && vec[ti].cyc == 32'(c)) begin
        chk("vec_h", o_def.h, vec[ti].h);
        chk("vec_v", o_def.v, vec[ti].v);
        chk("vec_hsync", 32'(d_hs), 32'(vec[ti].hs));
        chk("vec_visible", 32'(d_vis), 32'(vec[ti].vis));
        chk("vec_hblank", 32'(d_hbl), 32'(vec[ti].hbl));
        chk("vec_line_start", 32'(d_ls), 32'(vec[ti].ls));
        ti++;
      end
      if (c <= 551) begin
        if (s_vbs) begin vbs_cnt++; vbs_at = c; vbs_h = int'(o_sm.h); vbs_v = int'(o_sm.v); end
        if (!s_vs) vs_low++;
        if ((s_vs == 1'b0) != (o_sm.v >= 14 && o_sm.v < 16)) bad_vs++;
        if (s_wr != (o_sm.v >= 12)) bad_wr++;
        if (s_ls) ls_cnt++;
      end
      if (s_fs && fs_sm_at < 0) begin fs_sm_at = c; fs_sm_fc = int'(o_sm.fc); end
      if (q_pe != ((c % 2) == 1)) bad_pe++;
      if (o_dv.h != 32'((c / 2) % 29)) bad_h++;
      if (q_hs != (o_dv.h >= 22 && o_dv.h < 26)) bad_hs++;
      if (c < 1102 && q_hs) hs_hi++;
      if (c < 1102 && q_vs) vs_hi++;
      if (q_fs && fs_dv_at < 0) begin fs_dv_at = c; fs_dv_fc = int'(o_dv.fc); end
      tick();
    end
    chk("vec_all_applied", ti, NV);
    chk("sm_vblank_start_count", vbs_cnt, 1);
    chk("sm_vblank_start_cycle", vbs_at, 348);
    chk("sm_vblank_start_h", vbs_h, 0);
    chk("sm_vblank_start_v", vbs_v, 12);
    chk("sm_vsync_low_cycles", vs_low, 58);
    chk("sm_vsync_window_errs", bad_vs, 0);
    chk("sm_writable_errs", bad_wr, 0);
    chk("sm_line_start_count", ls_cnt, 19);
    chk("sm_frame_start_cycle", fs_sm_at, 551);
    chk("sm_frame_count_at_fs", fs_sm_fc, 1);
    chk("dv_pix_en_pattern_errs", bad_pe, 0);
    chk("dv_h_hold_errs", bad_h, 0);
    chk("dv_hsync_window_errs", bad_hs, 0);
    chk("dv_hsync_high_cycles", hs_hi, 152);
    chk("dv_vsync_high_cycles", vs_hi, 116);
    chk("dv_frame_start_cycle", fs_dv_at, 1102);
    chk("dv_frame_count_at_fs", fs_dv_fc, 1);

    // Freeze at (10,5) for 17 clocks, then resume.
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      #1;
      if (o_sm.h == 10 && o_sm.v == 5) found = 1'b1;
      else tick();
    end
    chk("reach_h10_v5", 32'(found), 1);
    en_sm = 1'b0;
    for (int i = 0; i < 17; i++) begin
      #1;
      chk("hold_h", o_sm.h, 10);
      chk("hold_v", o_sm.v, 5);
      chk("hold_no_pulse", {29'd0, s_ls, s_fs, s_vbs}, 0);
      chk("hold_pix_en", 32'(s_pe), 0);
      tick();
    end
    en_sm = 1'b1;
    #1;
    chk("resume_pix_en", 32'(s_pe), 1);
    tick();
    #1;
    chk("resume_h", o_sm.h, 11);

    // A pulse registered just before en_i drops still shows for one clock.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      #1;
      if (o_sm.h == 28) found = 1'b1;
      else tick();
    end
    chk("reach_h28", 32'(found), 1);
    tick();
    en_sm = 1'b0;
    #1;
    chk("late_pulse_ls", 32'(s_ls), 1);
    chk("late_pulse_h", o_sm.h, 0);
    tick();
    #1;
    chk("late_pulse_gone", 32'(s_ls), 0);
    chk("late_pulse_h_held", o_sm.h, 0);
    en_sm = 1'b1;

    // Reset inside both sync windows.
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      #1;
      if (o_sm.h == 23 && o_sm.v == 14) found = 1'b1;
      else tick();
    end
    chk("reach_h23_v14", 32'(found), 1);
    chk("fc_before_rst_nonzero", 32'(o_sm.fc != 0), 1);
    chk("in_sync_hsync", 32'(s_hs), 0);
    rst_sm = 1'b1;
    #1;
    chk("rst_mid_hsync", 32'(s_hs), 1);
    chk("rst_mid_vsync", 32'(s_vs), 1);
    chk("rst_mid_visible", 32'(s_vis), 0);
    chk("rst_mid_pix_en", 32'(s_pe), 0);
    tick();
    #1;
    chk("post_rst_h", o_sm.h, 0);
    chk("post_rst_v", o_sm.v, 0);
    chk("post_rst_fc", o_sm.fc, 0);
    chk("post_rst_fs", 32'(s_fs), 0);
    chk("post_rst_ls", 32'(s_ls), 0);
    rst_sm = 1'b0;

    // Five frames with a 2-bit frame counter.
    for (int f = 1; f <= 5; f++) begin
      found = 1'b0;
      for (int i = 0; i < 600 && !found; i++) begin
        #1;
        if (s_fs) found = 1'b1;
        else tick();
      end
      chk("frame_seen", 32'(found), 1);
      chk("frame_count_wrap", o_sm.fc, 32'(f % 4));
      chk("frame_pos_h", o_sm.h, 0);
      chk("frame_pos_v", o_sm.v, 0);
      tick();
    end

    // Random enables and occasional resets.
    for (int i = 0; i < 6000; i++) begin
      en_def  = ($urandom_range(0, 9) != 0);
      en_sm   = ($urandom_range(0, 9) != 0);
      en_dv   = ($urandom_range(0, 9) != 0);
      rst_def = ($urandom_range(0, 999) == 0);
      rst_sm  = ($urandom_range(0, 999) == 0);
      rst_dv  = ($urandom_range(0, 999) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
